// File: rtl/enable_reg.sv
// Parameterised storage register: async active-high reset to RESET_VAL,
// capture on wen, otherwise hold. dout comes straight from the flops.
module enable_reg #(
  parameter int WIDTH     = 1,
  parameter     RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // Any width of RESET_VAL is accepted; keep only the low WIDTH bits (zero-extend if narrower).
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (wen) val_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= RST_V;
    else     val_q <= val_d;
  end

  assign dout = val_q;

endmodule

// File: tb/tb_enable_reg.sv
// Bench for enable_reg: four parameterisations, a vector table, hand-written
// reset/flag sequences and a randomized run against a "last write since reset" model.
module tb_enable_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, RESET_VAL=A5
  logic       rst8, wen8;
  logic [7:0] din8, dout8;
  // WIDTH=32, RESET_VAL=0
  logic        rst32, wen32;
  logic [31:0] din32, dout32;
  // WIDTH=1 read-issued flag, din tied high
  logic rst1, rd_req, dout1;
  // WIDTH=4, RESET_VAL=8'h3C (truncates to C)
  logic       rst4, wen4;
  logic [3:0] din4, dout4;

  enable_reg #(.WIDTH(8),  .RESET_VAL(8'hA5)) u8  (.clk(clk), .rst(rst8),  .din(din8),  .dout(dout8),  .wen(wen8));
  enable_reg #(.WIDTH(32), .RESET_VAL(0))     u32 (.clk(clk), .rst(rst32), .din(din32), .dout(dout32), .wen(wen32));
  enable_reg #(.WIDTH(1),  .RESET_VAL(0))     u1  (.clk(clk), .rst(rst1),  .din(1'b1),  .dout(dout1),  .wen(rd_req));
  enable_reg #(.WIDTH(4),  .RESET_VAL(8'h3C)) u4  (.clk(clk), .rst(rst4),  .din(din4),  .dout(dout4),  .wen(wen4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] model;
    rst8 = 1; rst32 = 1; rst1 = 1; rst4 = 1;
    wen8 = 0; wen32 = 0; rd_req = 0; wen4 = 0;
    din8 = '0; din32 = '0; din4 = '0;

    // Reset values while rst held
    #3;
    chk("rst8",  32'(dout8),  32'h0000_00A5);
    chk("rst32", dout32,      32'h0);
    chk("rst1",  32'(dout1),  32'h0);
    chk("trunc4", 32'(dout4), 32'hC);
    @(negedge clk);
    rst8 = 0; rst32 = 0; rst1 = 0; rst4 = 0;

    // u8: write, then async reset between edges, hold reset 3 edges with wen=1
    din8 = 8'h3C; wen8 = 1;
    tick();
    chk("w8", 32'(dout8), 32'h3C);
    #2 rst8 = 1; din8 = 8'hFF;
    #1 chk("rst8_async", 32'(dout8), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst8_hold", 32'(dout8), 32'hA5);
    end
    @(negedge clk); rst8 = 0;
    tick();
    chk("w8_after_rst", 32'(dout8), 32'hFF);

    // u4: write truncation-free path, then reset back to C
    @(negedge clk); din4 = 4'h5; wen4 = 1;
    tick();
    chk("w4", 32'(dout4), 32'h5);
    #2 rst4 = 1;
    #1 chk("rst4_trunc", 32'(dout4), 32'hC);
    @(negedge clk); rst4 = 0; wen4 = 0;

    // u32 table: write, hold with toggling din, back-to-back, then 55AA55AA
    vecs.push_back('{1'b1, 32'hDEADBEEF, 32'hDEADBEEF});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, (i[0] ? 32'h12345678 : 32'hEDCBA987), 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h1, 32'h1});
    vecs.push_back('{1'b1, 32'h2, 32'h2});
    vecs.push_back('{1'b1, 32'h3, 32'h3});
    vecs.push_back('{1'b0, 32'h9, 32'h3});
    vecs.push_back('{1'b1, 32'h55AA55AA, 32'h55AA55AA});
    foreach (vecs[i]) begin
      @(negedge clk);
      wen32 = vecs[i].wen; din32 = vecs[i].din;
      #1 chk("vec_pre", dout32, (i == 0) ? 32'h0 : vecs[i-1].exp);
      tick();
      chk("vec", dout32, vecs[i].exp);
    end

    // Short reset pulse mid-cycle with a pending write
    @(posedge clk);
    #1 rst32 = 1; wen32 = 1; din32 = 32'hFFFFFFFF;
    #1 chk("pulse_rst", dout32, 32'h0);
    #2 rst32 = 0;
    #1 chk("pulse_rst_hold", dout32, 32'h0);
    tick();
    chk("pulse_after", dout32, 32'hFFFFFFFF);

    // Read-issued flag
    @(negedge clk); rd_req = 0;
    tick(); tick();
    chk("flag_idle", 32'(dout1), 32'h0);
    @(negedge clk); rd_req = 1;
    tick();
    chk("flag_set", 32'(dout1), 32'h1);
    @(negedge clk); rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flag_sticky", 32'(dout1), 32'h1);
    end
    #2 rst1 = 1;
    #1 chk("flag_clr", 32'(dout1), 32'h0);
    @(negedge clk); rst1 = 0;

    // Randomized: dout is the most recent din written since the last reset
    model = dout32;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) begin
        rst32 = 1;
        model = 32'h0;
      end else begin
        rst32 = 0;
      end
      wen32 = ($urandom_range(2) != 0);
      din32 = $urandom;
      #1 chk("rnd_mid", dout32, model);
      if (!rst32 && wen32) model = din32;
      tick();
      chk("rnd_edge", dout32, model);
    end
    @(negedge clk); rst32 = 0; wen32 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
